fx_arb: RTL and testbench
=========================

FX_ARB -- requirements
Module: fx_arb

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning the number of clk_sys cycles from the fx_rd pulse to the cycle in which fx_q is valid; legal range 1..15.
REQ-002 SHALL use one clock and one asynchronous active-low reset:
- clk_sys  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
REQ-003 SHALL have these master 0 ports (uart commu side):
- m0_req  input  1  request; level, held until m0_ack
- m0_we  input  1  1=write, 0=read
- m0_addr  input  22  target address
- m0_wdata  input  8  write data
- m0_ack  output  1  one-cycle completion pulse
- m0_rdata  output  8  read data, valid with m0_ack
REQ-004 SHALL have master 1 ports m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, identical in direction and width to REQ-003 (secondary/config master).
REQ-005 SHALL have these slave-side fx bus ports:
- fx_wr  output  1  write strobe
- fx_waddr  output  22  write address
- fx_data  output  8  write data
- fx_rd  output  1  read strobe
- fx_raddr  output  22  read address
- fx_q  input  8  OR-combined read data from all devices
REQ-006 SHALL have status ports busy (output, 1, high outside IDLE) and gnt_id (output, 1, master owning the current transaction).

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE, with all outputs registered.
REQ-008 SHALL sample m0_req and m1_req only in IDLE; in IDLE, any req moves the FSM to ISSUE and latches we/addr/wdata from the granted master.
REQ-009 SHALL arbitrate round-robin: with one req, grant it; with both, grant the master not granted last; after reset, last-granted is m1, so m0 wins the first tie.
REQ-010 In ISSUE, a write SHALL assert fx_wr=1 for exactly one cycle with fx_waddr/fx_data set to the latched values, then move to DONE.
REQ-011 In ISSUE, a read SHALL assert fx_rd=1 for exactly one cycle with fx_raddr set, load a 4-bit counter with RD_LAT, then move to WAIT.
REQ-012 In WAIT, the counter SHALL decrement each cycle; fx_q SHALL be captured at the edge closing the cycle RD_LAT cycles after the fx_rd cycle, and the FSM SHALL then enter DONE.
REQ-013 In DONE, the FSM SHALL pulse the granted master's ack for one cycle, update that master's rdata only for reads, and return to IDLE next cycle.
REQ-014 Latency from the req-sampled IDLE cycle (cycle 0) SHALL be: write fx_wr in cycle 1 and ack in cycle 2; read fx_rd in cycle 1 and ack in cycle 2+RD_LAT.
REQ-015 The master SHALL drop req the cycle after ack; a req still high in the next IDLE SHALL be treated as a new transaction.
REQ-016 fx_waddr, fx_data and fx_raddr SHALL hold their last values between strobes; fx_wr and fx_rd SHALL never be high together.
REQ-017 mN_rdata SHALL hold until the next read completion for that master; the non-granted master's ack and rdata SHALL be unaffected.
REQ-018 A req that rises during ISSUE, WAIT or DONE SHALL wait and be arbitrated in the next IDLE, with no loss.

Reset
REQ-019 On rst_n low, asynchronously: FSM=IDLE; fx_wr, fx_rd, m0_ack, m1_ack, busy, gnt_id =0; fx_waddr, fx_raddr =22'h0; fx_data, m0_rdata, m1_rdata =8'h0; counter=0; last-granted=m1.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction with no ack; masters SHALL reissue after reset.

Structure
REQ-021 A shared package (fx_pkg) SHALL hold FX_AW=22, FX_DW=8 and the FSM state encoding.
REQ-022 The block SHALL be a single module with no sub-module.

Verification
REQ-023 Write: m0 write addr 22'h010005, data 8'hA5 -> fx_wr high in cycle 1 with those values, m0_ack in cycle 2, m0_rdata unchanged.
REQ-024 Read with RD_LAT=2: m1 read addr 22'h200003, fx_q=8'h3C only in cycle 3 -> fx_rd in cycle 1, m1_ack in cycle 4, m1_rdata=8'h3C.
REQ-025 Tie: m0 and m1 both request reads repeatedly from reset -> grant order m0, m1, m0, m1; gnt_id matches; no back-to-back strobes closer than 3 cycles.
REQ-026 Late request: m1 raises req during m0's WAIT -> m1 is served in the first IDLE after m0_ack, with m0_rdata intact.
REQ-027 Reset mid-read: rst_n low in WAIT -> all outputs at reset values immediately, no ack; a subsequent m0 write completes normally.
REQ-028 RD_LAT=1 and RD_LAT=15: single read each -> ack at cycles 3 and 17 respectively, with correct data captured.

Source files
------------

// File: rtl/fx_pkg.sv
// fx_pkg: bus widths, read-latency counter width and FSM encoding
// shared by the fx bus arbiter (fx_arb).
package fx_pkg;
  localparam int FX_AW = 22;
  localparam int FX_DW = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } fx_state_t;
endpackage

// File: rtl/fx_arb.sv
// fx_arb: two-master round-robin arbiter onto the fx device bus.
// Ports: clk_sys/rst_n; m0_*/m1_* req/we/addr/wdata in, ack/rdata out;
// fx_wr/fx_waddr/fx_data, fx_rd/fx_raddr out, fx_q in; busy, gnt_id out.
module fx_arb
  import fx_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [FX_AW-1:0] m0_addr,
  input  logic [FX_DW-1:0] m0_wdata,
  output logic             m0_ack,
  output logic [FX_DW-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [FX_AW-1:0] m1_addr,
  input  logic [FX_DW-1:0] m1_wdata,
  output logic             m1_ack,
  output logic [FX_DW-1:0] m1_rdata,
  output logic             fx_wr,
  output logic [FX_AW-1:0] fx_waddr,
  output logic [FX_DW-1:0] fx_data,
  output logic             fx_rd,
  output logic [FX_AW-1:0] fx_raddr,
  input  logic [FX_DW-1:0] fx_q,
  output logic             busy,
  output logic             gnt_id
);

  fx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             pick;
  logic             gnt_d, busy_d;
  logic             wr_d, rd_d;
  logic             ack0_d, ack1_d;
  logic [FX_AW-1:0] waddr_d, raddr_d;
  logic [FX_DW-1:0] data_d;
  logic [FX_DW-1:0] rdata0_d, rdata1_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_id;
    pick     = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    waddr_d  = fx_waddr;
    raddr_d  = fx_raddr;
    data_d   = fx_data;
    rdata0_d = m0_rdata;
    rdata1_d = m1_rdata;

    unique case (state_q)
      IDLE: begin
        // On a tie the master not served last wins.
        unique case (1'b1)
          m0_req && m1_req:  pick = ~last_q;
          m1_req && !m0_req: pick = 1'b1;
          default:           pick = 1'b0;
        endcase
        if (m0_req || m1_req) begin
          state_d = ISSUE;
          gnt_d   = pick;
          last_d  = pick;
          if (pick ? m1_we : m0_we) begin
            wr_d    = 1'b1;
            waddr_d = pick ? m1_addr : m0_addr;
            data_d  = pick ? m1_wdata : m0_wdata;
          end else begin
            rd_d    = 1'b1;
            raddr_d = pick ? m1_addr : m0_addr;
          end
        end
      end
      ISSUE: begin
        if (fx_wr) begin
          state_d = DONE;
          ack0_d  = ~gnt_id;
          ack1_d  = gnt_id;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // cnt==1 marks the cycle RD_LAT after the strobe.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          ack0_d  = ~gnt_id;
          ack1_d  = gnt_id;
          if (gnt_id) rdata1_d = fx_q;
          else        rdata0_d = fx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_id   <= 1'b0;
      busy     <= 1'b0;
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      fx_waddr <= '0;
      fx_raddr <= '0;
      fx_data  <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_id   <= gnt_d;
      busy     <= busy_d;
      fx_wr    <= wr_d;
      fx_rd    <= rd_d;
      fx_waddr <= waddr_d;
      fx_raddr <= raddr_d;
      fx_data  <= data_d;
      m0_ack   <= ack0_d;
      m1_ack   <= ack1_d;
      m0_rdata <= rdata0_d;
      m1_rdata <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_fx_arb.sv
// tb_fx_arb: scoreboard bench for fx_arb at RD_LAT = 2, 1 and 15.
// Drivers push expected transactions; per-instance monitors check them.
module tb_fx_arb;

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
  } txn_t;

  logic clk;
  logic rst_n;

  logic        m0_req [3];
  logic        m0_we [3];
  logic [21:0] m0_addr [3];
  logic [7:0]  m0_wdata [3];
  logic        m0_ack [3];
  logic [7:0]  m0_rdata [3];
  logic        m1_req [3];
  logic        m1_we [3];
  logic [21:0] m1_addr [3];
  logic [7:0]  m1_wdata [3];
  logic        m1_ack [3];
  logic [7:0]  m1_rdata [3];
  logic        fx_wr [3];
  logic [21:0] fx_waddr [3];
  logic [7:0]  fx_data [3];
  logic        fx_rd [3];
  logic [21:0] fx_raddr [3];
  logic [7:0]  fx_q [3];
  logic        busy [3];
  logic        gnt_id [3];

  txn_t sbq [6][$];
  int   glog [3][$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device read data: fixed function of the address, never zero.
  function automatic logic [7:0] rom(input logic [21:0] a);
    logic [7:0] v;
    v = a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h1F;
    if (v == 8'h00) v = 8'hFF;
    return v;
  endfunction

  task automatic chk(input string n, input logic [95:0] act,
                     input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int g, input bit m, input bit r,
                        input bit we, input logic [21:0] a,
                        input logic [7:0] d);
    if (m) begin
      m1_req[g] = r; m1_we[g] = we; m1_addr[g] = a; m1_wdata[g] = d;
    end else begin
      m0_req[g] = r; m0_we[g] = we; m0_addr[g] = a; m0_wdata[g] = d;
    end
  endtask

  task automatic set_req(input int g, input bit m, input bit r);
    if (m) m1_req[g] = r;
    else   m0_req[g] = r;
  endtask

  task automatic do_txn(input int g, input bit m, input bit we,
                        input logic [21:0] a, input logic [7:0] d);
    txn_t t;
    bit   got;
    t.we = we; t.addr = a; t.wdata = d; t.rdata = rom(a);
    sbq[2*g+int'(m)].push_back(t);
    set_in(g, m, 1'b1, we, a, d);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = m ? m1_ack[g] : m0_ack[g];
    end
    chk($sformatf("g%0d m%0d ack_seen", g, m), 96'(got), 96'(1));
    tick();
    set_req(g, m, 1'b0);
  endtask

  task automatic reads2(input int g, input bit m);
    do_txn(g, m, 1'b0, 22'(22'h030000 + g*16 + int'(m)*4), 8'h00);
    do_txn(g, m, 1'b0, 22'(22'h030001 + g*16 + int'(m)*4), 8'h00);
  endtask

  task automatic rand_master(input int g, input bit m, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_txn(g, m, 1'($urandom_range(0, 1)), 22'($urandom), 8'($urandom));
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    fx_arb #(.RD_LAT(LAT)) dut (
      .clk_sys  (clk),
      .rst_n    (rst_n),
      .m0_req   (m0_req[g]),
      .m0_we    (m0_we[g]),
      .m0_addr  (m0_addr[g]),
      .m0_wdata (m0_wdata[g]),
      .m0_ack   (m0_ack[g]),
      .m0_rdata (m0_rdata[g]),
      .m1_req   (m1_req[g]),
      .m1_we    (m1_we[g]),
      .m1_addr  (m1_addr[g]),
      .m1_wdata (m1_wdata[g]),
      .m1_ack   (m1_ack[g]),
      .m1_rdata (m1_rdata[g]),
      .fx_wr    (fx_wr[g]),
      .fx_waddr (fx_waddr[g]),
      .fx_data  (fx_data[g]),
      .fx_rd    (fx_rd[g]),
      .fx_raddr (fx_raddr[g]),
      .fx_q     (fx_q[g]),
      .busy     (busy[g]),
      .gnt_id   (gnt_id[g])
    );

    // Device: drives fx_q only in the cycle LAT after the read strobe.
    int          dc;
    logic [21:0] da;
    always @(posedge clk) begin
      if (!rst_n) begin
        dc = 0;
        fx_q[g] <= 8'h00;
      end else begin
        fx_q[g] <= 8'h00;
        if (fx_rd[g]) begin
          dc = LAT;
          da = fx_raddr[g];
        end
        if (dc == 1) fx_q[g] <= rom(da);
        if (dc > 0) dc--;
      end
    end

    // Reference model: grant decision, strobe/ack cycle, held rdata.
    int         cyc, exp_s, exp_a, last_s;
    bit         bsy, eg, lastg, egnt, acked;
    logic [7:0] h0, h1;
    txn_t       cur;
    always @(negedge clk) begin
      if (!rst_n) begin
        bsy = 0; lastg = 1; egnt = 0; h0 = 0; h1 = 0;
        cyc = 0; last_s = -10;
      end else begin
        cyc++;
        acked = 0;
        chk($sformatf("g%0d excl", g), 96'(fx_wr[g] & fx_rd[g]), 96'(0));
        if (bsy && cyc == exp_s) begin
          chk($sformatf("g%0d strobe", g), 96'({fx_wr[g], fx_rd[g]}),
              96'({cur.we, !cur.we}));
          chk($sformatf("g%0d st_addr", g),
              96'(cur.we ? fx_waddr[g] : fx_raddr[g]), 96'(cur.addr));
          if (cur.we)
            chk($sformatf("g%0d st_data", g), 96'(fx_data[g]),
                96'(cur.wdata));
          chk($sformatf("g%0d st_gap", g), 96'(cyc - last_s >= 3), 96'(1));
          last_s = cyc;
          egnt = eg;
        end else begin
          chk($sformatf("g%0d stray", g), 96'(fx_wr[g] | fx_rd[g]), 96'(0));
        end
        chk($sformatf("g%0d busy", g), 96'(busy[g]),
            96'(bsy && cyc >= exp_s));
        chk($sformatf("g%0d gnt", g), 96'(gnt_id[g]), 96'(egnt));
        if (bsy && cyc == exp_a) begin
          chk($sformatf("g%0d ack", g), 96'({m1_ack[g], m0_ack[g]}),
              96'(eg ? 2'b10 : 2'b01));
          if (!cur.we) begin
            if (eg) h1 = cur.rdata;
            else    h0 = cur.rdata;
          end
          void'(sbq[2*g+int'(eg)].pop_front());
          bsy = 0;
          acked = 1;
        end else begin
          chk($sformatf("g%0d ack", g), 96'({m1_ack[g], m0_ack[g]}),
              96'(0));
        end
        chk($sformatf("g%0d rdata", g), 96'({m1_rdata[g], m0_rdata[g]}),
            96'({h1, h0}));
        if (!bsy && !acked && (m0_req[g] || m1_req[g])) begin
          eg = (m0_req[g] && m1_req[g]) ? !lastg : m1_req[g];
          lastg = eg;
          if (sbq[2*g+int'(eg)].size() == 0) begin
            chk($sformatf("g%0d sb_txn", g), 96'(0), 96'(1));
          end else begin
            cur = sbq[2*g+int'(eg)][0];
            bsy = 1;
            exp_s = cyc + 1;
            exp_a = cur.we ? cyc + 2 : cyc + 2 + LAT;
            glog[g].push_back(int'(eg));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      set_in(g, 1'b0, 1'b0, 1'b0, 22'h0, 8'h0);
      set_in(g, 1'b1, 1'b0, 1'b0, 22'h0, 8'h0);
    end
    repeat (3) tick();
    for (int g = 0; g < 3; g++)
      chk($sformatf("g%0d rst_vals", g),
          96'({fx_wr[g], fx_rd[g], m0_ack[g], m1_ack[g], busy[g],
               gnt_id[g], fx_waddr[g], fx_raddr[g], fx_data[g],
               m0_rdata[g], m1_rdata[g]}), 96'(0));
    rst_n = 1'b1;

    // Tie from reset: grants must alternate starting with m0.
    fork
      reads2(0, 1'b0); reads2(0, 1'b1);
      reads2(1, 1'b0); reads2(1, 1'b1);
      reads2(2, 1'b0); reads2(2, 1'b1);
    join
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("g%0d tie_n", g), 96'(glog[g].size()), 96'(4));
      for (int k = 0; k < 4 && k < glog[g].size(); k++)
        chk($sformatf("g%0d tie_%0d", g, k), 96'(glog[g][k]), 96'(k % 2));
      glog[g].delete();
    end

    do_txn(0, 1'b0, 1'b1, 22'h010005, 8'hA5);
    do_txn(0, 1'b1, 1'b0, 22'h200003, 8'h00);
    chk("m1_rdata_3c", 96'(m1_rdata[0]), 96'(8'h3C));

    fork
      do_txn(1, 1'b0, 1'b0, 22'h0001F0, 8'h00);
      do_txn(2, 1'b1, 1'b0, 22'h3FFFFF, 8'h00);
    join

    // m1 asks while m0's read is in flight.
    fork
      do_txn(0, 1'b0, 1'b0, 22'h055AA0, 8'h00);
      begin
        tick();
        tick();
        do_txn(0, 1'b1, 1'b1, 22'h2ABCDE, 8'h77);
      end
    join
    chk("m0_rdata_kept", 96'(m0_rdata[0]), 96'(rom(22'h055AA0)));

    fork
      rand_master(0, 1'b0, 20); rand_master(0, 1'b1, 20);
      rand_master(1, 1'b0, 20); rand_master(1, 1'b1, 20);
      rand_master(2, 1'b0, 20); rand_master(2, 1'b1, 20);
    join

    // Abort a read in WAIT with reset.
    tick();
    sbq[0].push_back('{we: 1'b0, addr: 22'h15A5A5, wdata: 8'h00,
                       rdata: rom(22'h15A5A5)});
    set_in(0, 1'b0, 1'b1, 1'b0, 22'h15A5A5, 8'h00);
    tick();
    tick();
    chk("pre_rst_busy", 96'(busy[0]), 96'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vals",
        96'({fx_wr[0], fx_rd[0], m0_ack[0], m1_ack[0], busy[0],
             gnt_id[0], fx_waddr[0], fx_raddr[0], fx_data[0],
             m0_rdata[0], m1_rdata[0]}), 96'(0));
    sbq[0].delete();
    set_req(0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    do_txn(0, 1'b0, 1'b1, 22'h0ABCDE, 8'h5C);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
